id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS pipeline; captures the rs/rt operands read from the register file, plus the decoded control fields, on each rising clock edge.
- Resolves RAW hazards at capture time:
  - forwards results from the EX, MEM and WB stages into the operand latches;
  - stalls IF/ID on load-use hazards, inserting bubbles into EX.
- Consumes the flush request from branch/jump resolution.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width
OP_W, 4, ALU opcode width

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  decode holds a real instruction
id_pc  in  DATA_W  PC of decoding instruction
id_rs_addr  in  ADDR_W  rs index
id_rt_addr  in  ADDR_W  rt index
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rs_data  in  DATA_W  rs value from register file
id_rt_data  in  DATA_W  rt value from register file
id_imm  in  DATA_W  extended immediate
id_dest  in  ADDR_W  destination register
id_write_reg  in  1  instruction writes a register
id_mem_read  in  1  instruction is a load
id_mem_write  in  1  instruction is a store
id_alu_op  in  OP_W  ALU operation
ex_result  in  DATA_W  combinational ALU result of the instruction now in EX
mem_dest  in  ADDR_W  destination of the instruction in MEM
mem_write_reg  in  1  MEM instruction writes a register
mem_mem_read  in  1  MEM instruction is a load
mem_result  in  DATA_W  ALU result held in MEM
wb_dest  in  ADDR_W  WB destination
wb_write_reg  in  1  WB writes a register
wb_data  in  DATA_W  WB write data
flush  in  1  discard the instruction in decode (taken branch/jump)
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_write_reg, ex_mem_read, ex_mem_write, ex_alu_op  out  (widths as the id_ counterparts)  registered EX-stage fields

Behaviour:
- Reset: async on rst high; every ex_ output clears to 0; stall reads 0 while in reset.
- Hazard term: a source is "live" when its use flag is set, its address is nonzero and id_valid=1.
  - hit_EX: live source equals ex_dest, with ex_valid and ex_write_reg set.
  - hit_MEM: live source equals mem_dest, with mem_write_reg set.
  - hit_WB: live source equals wb_dest, with wb_write_reg set.
- Load-use stall:
  - Raised when any live source has hit_EX with ex_mem_read=1, or hit_MEM with mem_mem_read=1.
  - Consequence: a dependent instruction directly behind a load stalls 2 cycles, and one a single slot behind stalls 1 cycle.
  - stall is suppressed when flush=1.
- Capture on rising edge, evaluated in priority order:
  1. flush=1 → bubble: ex_valid, ex_write_reg, ex_mem_read and ex_mem_write go to 0; other fields are don't-care and are driven to 0.
  2. stall=1 → bubble, as above; the decode instruction is re-presented next cycle because IF/ID holds.
  3. Otherwise all id_ fields are latched, and ex_valid=id_valid.
- Operand select, per source:
  - address 0 → 0;
  - else hit_EX → ex_result;
  - else hit_MEM → mem_result;
  - else hit_WB → wb_data;
  - else id_*_data.
  - The youngest producer wins; register 0 never forwards.
- Sources with use flag 0 are latched unmodified from id_*_data.
- Simultaneous flush and stall: flush wins, no stall is raised, and the decode instruction is dropped.
- Reset mid-stall: the stall condition vanishes because ex_ is cleared, and the pipeline resumes on the first edge after rst falls.
- No internal counters beyond the registered ex_ state.
- The stall sequence is an implicit two-state FSM, RUN/BUBBLE, derived from the ex_ and mem_ load flags.

Optional Feature:
- Macro ID_EX_BYPASS_EN.
- Defined: forwarding as above, plus load-use stalls only.
- Undefined: the forwarding muxes are removed, and the operand is always id_*_data (0 for address 0).
  - stall is raised on any live hit_EX or hit_MEM regardless of load flags.
  - WB hazards rely on the register file's same-cycle write bypass and never stall.

Test Plan:
- rst pulse mid-run with ex_valid=1 → all ex_ outputs 0 immediately (asynchronously), stall=0.
- EX holds add dest=$8, ex_result=0x0000_1234; decode reads rs=$8 → next edge ex_rs_data=0x0000_1234, stall=0.
- Same dest in EX and MEM (ex_result=0xA, mem_result=0xB) → ex_rs_data=0xA. With rs=$0 and a matching $0 write → ex_rs_data=0.
- lw $9 in EX, decode add uses rt=$9 → stall=1 for exactly 2 cycles, two bubbles (ex_valid=0), then ex_rt_data=wb_data=0xDEAD_BEEF.
- Load-use condition with flush=1 same cycle → stall=0, next ex_valid=0.
- Build without ID_EX_BYPASS_EN: ALU dependency on EX → stall 2 cycles, then ex_rs_data equals the register-file value.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with RAW hazard resolution (forwarding and load-use stall).
// Define ID_EX_BYPASS_EN to enable EX/MEM/WB forwarding; otherwise any EX/MEM dependency stalls.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_write_reg,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              mem_write_reg,
  input  logic              mem_mem_read,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_write_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [OP_W-1:0]   ex_alu_op
);
  logic w_live_rs, w_live_rt, w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_hazard, w_bubble;
  logic [DATA_W-1:0] w_rs_data, w_rt_data;
`ifndef ID_EX_BYPASS_EN
  logic w_unused;
  assign w_unused = ^{ex_result, mem_result, wb_dest, wb_write_reg, wb_data};
`endif
  always_comb begin
    w_live_rs = id_valid && id_use_rs && (id_rs_addr != '0);
    w_live_rt = id_valid && id_use_rt && (id_rt_addr != '0);
    w_ex_rs   = w_live_rs && ex_valid && ex_write_reg && (id_rs_addr == ex_dest);
    w_ex_rt   = w_live_rt && ex_valid && ex_write_reg && (id_rt_addr == ex_dest);
    w_mem_rs  = w_live_rs && mem_write_reg && (id_rs_addr == mem_dest);
    w_mem_rt  = w_live_rt && mem_write_reg && (id_rt_addr == mem_dest);
`ifdef ID_EX_BYPASS_EN
    w_hazard  = ((w_ex_rs || w_ex_rt) && ex_mem_read) || ((w_mem_rs || w_mem_rt) && mem_mem_read);
    w_rs_data = (id_use_rs && id_rs_addr == '0) ? '0 : w_ex_rs ? ex_result : w_mem_rs ? mem_result :
                (w_live_rs && wb_write_reg && id_rs_addr == wb_dest) ? wb_data : id_rs_data;
    w_rt_data = (id_use_rt && id_rt_addr == '0) ? '0 : w_ex_rt ? ex_result : w_mem_rt ? mem_result :
                (w_live_rt && wb_write_reg && id_rt_addr == wb_dest) ? wb_data : id_rt_data;
`else
    // WB producers are covered by the register file's write-through, so only EX/MEM stall
    w_hazard  = w_ex_rs || w_ex_rt || w_mem_rs || w_mem_rt;
    w_rs_data = (id_use_rs && id_rs_addr == '0) ? '0 : id_rs_data;
    w_rt_data = (id_use_rt && id_rt_addr == '0) ? '0 : id_rt_data;
`endif
    stall     = w_hazard && !flush && !rst;
    w_bubble  = flush || stall;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_dest      <= '0;
      ex_write_reg <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_op    <= '0;
    end else begin
      ex_valid     <= !w_bubble && id_valid;
      ex_pc        <= w_bubble ? '0 : id_pc;
      ex_rs_data   <= w_bubble ? '0 : w_rs_data;
      ex_rt_data   <= w_bubble ? '0 : w_rt_data;
      ex_imm       <= w_bubble ? '0 : id_imm;
      ex_dest      <= w_bubble ? '0 : id_dest;
      ex_write_reg <= !w_bubble && id_write_reg;
      ex_mem_read  <= !w_bubble && id_mem_read;
      ex_mem_write <= !w_bubble && id_mem_write;
      ex_alu_op    <= w_bubble ? '0 : id_alu_op;
    end
  end
endmodule
